// File: rtl/dlx_mem_pkg.sv
// Shared encodings and defaults for the DLX/host memory bus arbiter.
// Arbiter state codes, owner codes and the latched memory command layout.
package dlx_mem_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACCESS = 2'b01;
  localparam logic [1:0] ST_DONE   = 2'b10;

  localparam int          DEF_WAIT_LIMIT   = 15;
  localparam logic [31:0] DEF_TIMEOUT_DATA = 32'hFFFF_FFFF;

  localparam logic OWNER_DLX  = 1'b0;
  localparam logic OWNER_HOST = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } mem_cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin decision: a lone requester wins, a tie goes to the
// requester that did not win last time. req[0] is the DLX, req[1] the host.
module rr_arb2
  import dlx_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt
);

  always_comb begin
    gnt = last;
    case (req)
      2'b01:   gnt = OWNER_DLX;
      2'b10:   gnt = OWNER_HOST;
      2'b11:   gnt = ~last;
      default: gnt = last;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates a DLX controller port and a host/loader port onto one memory
// command bus, with a bounded wait for MEM_ACK and a sticky timeout flag.
module mem_bus_arbiter
  import dlx_mem_pkg::*;
#(
  parameter int          WAIT_LIMIT   = DEF_WAIT_LIMIT,
  parameter logic [31:0] TIMEOUT_DATA = DEF_TIMEOUT_DATA
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        DLX_MR,
  input  logic        DLX_MW,
  input  logic [31:0] DLX_ADDR,
  input  logic [31:0] DLX_WDATA,
  output logic        DLX_BUSY,
  output logic [31:0] DLX_RDATA,
  input  logic        HOST_RD,
  input  logic        HOST_WR,
  input  logic [31:0] HOST_ADDR,
  input  logic [31:0] HOST_WDATA,
  output logic        HOST_BUSY,
  output logic [31:0] HOST_RDATA,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic        MEM_RE,
  output logic        MEM_WE,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  output logic        TIMEOUT_ERR,
  input  logic        ERR_CLR,
  output logic        GNT_HOST,
  output logic [1:0]  ARB_STATE
);

  localparam int              CNT_W    = $clog2(WAIT_LIMIT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  mem_cmd_t         cmd;
  mem_cmd_t         win_cmd;
  logic [31:0]      dlx_rdata_q;
  logic [31:0]      host_rdata_q;
  logic             err_q;

  logic        dlx_req;
  logic        host_req;
  logic        any_req;
  logic        winner;
  logic        timeout_hit;
  logic        finish;
  logic [31:0] rd_val;

  assign dlx_req  = DLX_MR | DLX_MW;
  assign host_req = HOST_RD | HOST_WR;
  assign any_req  = dlx_req | host_req;

  rr_arb2 u_rr_arb2 (
    .req  ({host_req, dlx_req}),
    .last (owner),
    .gnt  (winner)
  );

  // A requester raising both read and write is served as a write.
  always_comb begin
    win_cmd = '{addr: DLX_ADDR, wdata: DLX_WDATA, we: DLX_MW};
    if (winner == OWNER_HOST) begin
      win_cmd = '{addr: HOST_ADDR, wdata: HOST_WDATA, we: HOST_WR};
    end
  end

  // MEM_ACK in the final wait cycle still counts as a normal completion.
  assign timeout_hit = (state == ST_ACCESS) && !MEM_ACK && (cnt == CNT_LAST);
  assign finish      = (state == ST_ACCESS) && (MEM_ACK || timeout_hit);
  assign rd_val      = MEM_ACK ? MEM_RDATA : TIMEOUT_DATA;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      cnt   <= '0;
      owner <= OWNER_HOST;
      cmd   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            cmd   <= win_cmd;
            owner <= winner;
            cnt   <= '0;
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          cnt <= cnt + CNT_W'(1);
          if (finish) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read data registers change only when a read of that port completes.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dlx_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else if (finish && !cmd.we) begin
      if (owner == OWNER_DLX) begin
        dlx_rdata_q <= rd_val;
      end else begin
        host_rdata_q <= rd_val;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end else if (ERR_CLR) begin
      err_q <= 1'b0;
    end
  end

  // Strobes decode from state so a reset removes them without waiting for a clock.
  assign MEM_ADDR  = cmd.addr;
  assign MEM_WDATA = cmd.wdata;
  assign MEM_RE    = (state == ST_ACCESS) && !cmd.we;
  assign MEM_WE    = (state == ST_ACCESS) && cmd.we;

  assign DLX_BUSY   = dlx_req  && !((state == ST_DONE) && (owner == OWNER_DLX));
  assign HOST_BUSY  = host_req && !((state == ST_DONE) && (owner == OWNER_HOST));
  assign DLX_RDATA  = dlx_rdata_q;
  assign HOST_RDATA = host_rdata_q;

  assign TIMEOUT_ERR = err_q;
  assign GNT_HOST    = owner;
  assign ARB_STATE   = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a memory responder model, a completion
// scoreboard fed by the stimulus, and inline checks of bus strobes and timing.
module tb_mem_bus_arbiter;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        DLX_MR = 1'b0, DLX_MW = 1'b0;
  logic [31:0] DLX_ADDR = '0, DLX_WDATA = '0;
  logic        DLX_BUSY;
  logic [31:0] DLX_RDATA;
  logic        HOST_RD = 1'b0, HOST_WR = 1'b0;
  logic [31:0] HOST_ADDR = '0, HOST_WDATA = '0;
  logic        HOST_BUSY;
  logic [31:0] HOST_RDATA;
  logic [31:0] MEM_ADDR, MEM_WDATA;
  logic        MEM_RE, MEM_WE;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;
  logic        TIMEOUT_ERR;
  logic        ERR_CLR = 1'b0;
  logic        GNT_HOST;
  logic [1:0]  ARB_STATE;

  // Responder controls and observations.
  logic        resp_ack = 1'b0;
  logic [31:0] resp_rdata = '0;
  logic        stray_ack = 1'b0;
  logic        ack_en = 1'b1;
  int          ack_delay = 0;
  logic [31:0] ack_data = '0;
  int          acc_cnt = 0;
  int          re_cycles = 0;
  int          we_cycles = 0;
  logic [31:0] seen_addr = '0;
  logic [31:0] seen_wdata = '0;

  int checks = 0;
  int failures = 0;
  // Entry layout: {port, check_rdata, expected_err, expected_rdata}.
  logic [34:0] exp_q[$];
  int lat;

  assign MEM_ACK   = resp_ack | stray_ack;
  assign MEM_RDATA = stray_ack ? 32'hBAD0_BAD0 : resp_rdata;

  mem_bus_arbiter dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .DLX_MR      (DLX_MR),
    .DLX_MW      (DLX_MW),
    .DLX_ADDR    (DLX_ADDR),
    .DLX_WDATA   (DLX_WDATA),
    .DLX_BUSY    (DLX_BUSY),
    .DLX_RDATA   (DLX_RDATA),
    .HOST_RD     (HOST_RD),
    .HOST_WR     (HOST_WR),
    .HOST_ADDR   (HOST_ADDR),
    .HOST_WDATA  (HOST_WDATA),
    .HOST_BUSY   (HOST_BUSY),
    .HOST_RDATA  (HOST_RDATA),
    .MEM_ADDR    (MEM_ADDR),
    .MEM_WDATA   (MEM_WDATA),
    .MEM_RE      (MEM_RE),
    .MEM_WE      (MEM_WE),
    .MEM_ACK     (MEM_ACK),
    .MEM_RDATA   (MEM_RDATA),
    .TIMEOUT_ERR (TIMEOUT_ERR),
    .ERR_CLR     (ERR_CLR),
    .GNT_HOST    (GNT_HOST),
    .ARB_STATE   (ARB_STATE)
  );

  // Clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // Memory responder: ack after ack_delay strobe cycles, junk data otherwise.
  always @(posedge CLK) begin
    #1;
    if (RESET || !(MEM_RE || MEM_WE)) begin
      resp_ack   = 1'b0;
      resp_rdata = 32'h0BAD_0000;
      acc_cnt    = 0;
    end else begin
      resp_ack   = ack_en && (acc_cnt == ack_delay);
      resp_rdata = resp_ack ? ack_data : 32'h0BAD_0000;
      acc_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic expect_done(input logic port, input logic chk, input logic err,
                             input logic [31:0] rdata);
    exp_q.push_back({port, chk, err, rdata});
  endtask

  task automatic sb_check(input logic port, input logic [31:0] rdata);
    logic [34:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_unexpected_done actual=port%0d required=none", port);
    end else begin
      e = exp_q.pop_front();
      check("sb_port", 32'(port), 32'(e[34]));
      check("sb_gnt_host", 32'(GNT_HOST), 32'(e[34]));
      check("sb_timeout_err", 32'(TIMEOUT_ERR), 32'(e[32]));
      if (e[33]) check("sb_rdata", rdata, e[31:0]);
    end
  endtask

  // Monitor: strobe bookkeeping and completion scoreboard.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (MEM_RE) begin
        re_cycles++;
        seen_addr = MEM_ADDR;
      end
      if (MEM_WE) begin
        we_cycles++;
        seen_addr  = MEM_ADDR;
        seen_wdata = MEM_WDATA;
      end
      if ((DLX_MR || DLX_MW) && !DLX_BUSY) sb_check(1'b0, DLX_RDATA);
      if ((HOST_RD || HOST_WR) && !HOST_BUSY) sb_check(1'b1, HOST_RDATA);
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic port, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      HOST_RD = rd; HOST_WR = wr; HOST_ADDR = addr; HOST_WDATA = wdata;
    end else begin
      DLX_MR = rd; DLX_MW = wr; DLX_ADDR = addr; DLX_WDATA = wdata;
    end
  endtask

  task automatic wait_done(input logic port, output int cycles);
    bit done;
    done   = 1'b0;
    cycles = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge CLK);
      if (port ? !HOST_BUSY : !DLX_BUSY) done = 1'b1;
      else cycles++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL wait_done_port%0d actual=busy required=done", port);
    end
  endtask

  task automatic release_port(input logic port);
    step();
    drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;

    // Reset state
    @(negedge CLK);
    check("rst_state", 32'(ARB_STATE), 32'd0);
    check("rst_dlx_busy", 32'(DLX_BUSY), 32'd0);
    check("rst_host_busy", 32'(HOST_BUSY), 32'd0);
    check("rst_dlx_rdata", DLX_RDATA, 32'd0);
    check("rst_host_rdata", HOST_RDATA, 32'd0);
    check("rst_err", 32'(TIMEOUT_ERR), 32'd0);
    check("rst_re", 32'(MEM_RE), 32'd0);
    check("rst_we", 32'(MEM_WE), 32'd0);
    check("rst_gnt_host", 32'(GNT_HOST), 32'd1);
    check("rst_mem_addr", MEM_ADDR, 32'd0);

    // DLX read, immediate ack: minimum latency, one-cycle MEM_RE
    ack_en = 1'b1; ack_delay = 0; ack_data = 32'h1234_5678; re_cycles = 0;
    step();
    expect_done(1'b0, 1'b1, 1'b0, 32'h1234_5678);
    drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    wait_done(1'b0, lat);
    check("min_latency", 32'(lat), 32'd2);
    check("re_one_cycle", 32'(re_cycles), 32'd1);
    check("rd_addr_40", seen_addr, 32'h40);
    release_port(1'b0);

    // Tie from reset: DLX first, host held then served
    do_reset();
    ack_delay = 1; ack_data = 32'hAAAA_0001;
    expect_done(1'b0, 1'b1, 1'b0, 32'hAAAA_0001);
    expect_done(1'b1, 1'b1, 1'b0, 32'hBBBB_0002);
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    wait_done(1'b0, lat);
    check("tie_host_held", 32'(HOST_BUSY), 32'd1);
    check("tie_dlx_latency", 32'(lat), 32'd3);
    ack_data = 32'hBBBB_0002;
    release_port(1'b0);
    wait_done(1'b1, lat);
    check("tie_host_gnt", 32'(GNT_HOST), 32'd1);
    check("tie_host_addr", seen_addr, 32'h20);
    release_port(1'b1);

    // Host write timeout, then ERR_CLR pulse
    ack_en = 1'b0; we_cycles = 0;
    step();
    expect_done(1'b1, 1'b0, 1'b1, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 32'h100, 32'hCAFE_BABE);
    wait_done(1'b1, lat);
    check("timeout_latency", 32'(lat), 32'd16);
    check("timeout_we_cycles", 32'(we_cycles), 32'd15);
    check("timeout_wr_addr", seen_addr, 32'h100);
    check("timeout_wr_data", seen_wdata, 32'hCAFE_BABE);
    release_port(1'b1);
    step();
    check("err_sticky", 32'(TIMEOUT_ERR), 32'd1);
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    check("err_cleared", 32'(TIMEOUT_ERR), 32'd0);

    // DLX read timeout with ERR_CLR held: timeout wins, data is TIMEOUT_DATA
    ERR_CLR = 1'b1;
    step();
    expect_done(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    drive(1'b0, 1'b1, 1'b0, 32'h44, 32'h0);
    wait_done(1'b0, lat);
    release_port(1'b0);
    ERR_CLR = 1'b0;
    step();
    check("err_clr_after_timeout", 32'(TIMEOUT_ERR), 32'd0);

    // Ack in the last permitted ACCESS cycle is a normal completion
    ack_en = 1'b1; ack_delay = 14; ack_data = 32'h0F0F_0F0F;
    expect_done(1'b1, 1'b1, 1'b0, 32'h0F0F_0F0F);
    drive(1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
    wait_done(1'b1, lat);
    check("last_cycle_ack_latency", 32'(lat), 32'd16);
    release_port(1'b1);

    // Host read withdrawn mid-ACCESS: completes silently
    ack_delay = 2; ack_data = 32'h5A5A_1234;
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h400, 32'h0);
    step();
    step();
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("withdraw_still_access", 32'(ARB_STATE), 32'd1);
    check("withdraw_re_held", 32'(MEM_RE), 32'd1);
    step();
    check("withdraw_done_state", 32'(ARB_STATE), 32'd2);
    check("withdraw_host_busy", 32'(HOST_BUSY), 32'd0);
    step();
    check("withdraw_back_idle", 32'(ARB_STATE), 32'd0);
    check("withdraw_rdata", HOST_RDATA, 32'h5A5A_1234);

    // DLX read+write together is a write; DLX_RDATA holds the earlier read
    ack_delay = 0; re_cycles = 0; we_cycles = 0;
    expect_done(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 32'h8, 32'h5555_AAAA);
    wait_done(1'b0, lat);
    check("rdwr_we_cycles", 32'(we_cycles), 32'd1);
    check("rdwr_re_cycles", 32'(re_cycles), 32'd0);
    check("rdwr_addr", seen_addr, 32'h8);
    check("rdwr_wdata", seen_wdata, 32'h5555_AAAA);
    check("rdata_hold", DLX_RDATA, 32'hFFFF_FFFF);
    release_port(1'b0);

    // Tie after a DLX grant: host wins this time
    ack_data = 32'h7777_8888;
    step();
    expect_done(1'b1, 1'b0, 1'b0, 32'h0);
    expect_done(1'b0, 1'b1, 1'b0, 32'h7777_8888);
    drive(1'b0, 1'b1, 1'b0, 32'h50, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 32'h60, 32'h1357_9BDF);
    wait_done(1'b1, lat);
    check("rr_dlx_held", 32'(DLX_BUSY), 32'd1);
    check("rr_host_wdata", seen_wdata, 32'h1357_9BDF);
    release_port(1'b1);
    wait_done(1'b0, lat);
    release_port(1'b0);

    // Stray MEM_ACK in IDLE is ignored
    step();
    stray_ack = 1'b1;
    step();
    step();
    check("stray_state", 32'(ARB_STATE), 32'd0);
    check("stray_dlx_rdata", DLX_RDATA, 32'h7777_8888);
    check("stray_host_rdata", HOST_RDATA, 32'h5A5A_1234);
    stray_ack = 1'b0;

    // Reset during ACCESS abandons the transaction
    ack_en = 1'b0;
    step();
    drive(1'b0, 1'b1, 1'b0, 32'h700, 32'h0);
    step();
    step();
    step();
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    check("async_rst_re", 32'(MEM_RE), 32'd0);
    check("async_rst_state", 32'(ARB_STATE), 32'd0);
    check("async_rst_gnt", 32'(GNT_HOST), 32'd1);
    check("async_rst_rdata", DLX_RDATA, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    RESET = 1'b0;
    ack_en = 1'b1; ack_delay = 0;
    step();
    expect_done(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 32'h800, 32'h2468_ACE0);
    wait_done(1'b0, lat);
    check("post_rst_latency", 32'(lat), 32'd2);
    check("post_rst_wdata", seen_wdata, 32'h2468_ACE0);
    release_port(1'b0);

    step();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
